phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
//  Allocator for the physical register file shared by all in-flight instructions.
//  Hands one free physical tag per cycle to the rename stage for a new destination.
//  Reclaims up to two tags per cycle from commit: the old mappings of retired dests.
//  Drives the rename stall when no tag is available.
// PARAMETERS
//  NUM_PREGS  64  physical registers; tags are 0..NUM_PREGS-1
//  NUM_AREGS  32  architectural registers; p0..p31 are mapped at reset, never on the list
//  TAG_W      6   tag width, equal to $clog2(NUM_PREGS)
//  FL_DEPTH   32  free-list capacity, equal to NUM_PREGS-NUM_AREGS
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rstn         in   1      async active-low reset
//  alloc_req    in   1      rename needs a dest tag this cycle (dr!=0 and regWrite)
//  alloc_tag    out  TAG_W  tag at head; valid when alloc_valid=1
//  alloc_valid  out  1      list non-empty; alloc_req&alloc_valid pops at posedge
//  stall_out    out  1      alloc_req & ~alloc_valid (combinational)
//  rel0_valid   in   1      commit slot 0 releases rel0_tag
//  rel0_tag     in   TAG_W  tag being freed by slot 0
//  rel1_valid   in   1      commit slot 1 releases rel1_tag
//  rel1_tag     in   TAG_W  tag being freed by slot 1
//  free_count   out  TAG_W  number of tags currently on the list (0..FL_DEPTH)
//  overflow_err out  1      sticky: a release was dropped because the list was full
// BEHAVIOUR
//  Storage: circular buffer fl[FL_DEPTH] of TAG_W; head/tail ptrs $clog2(FL_DEPTH)
//   bits, wrap FL_DEPTH-1 -> 0; count register holds occupancy.
//  Reset (async, rstn=0): fl[i]=NUM_AREGS+i; head=0; tail=0; count=FL_DEPTH;
//   alloc_tag=NUM_AREGS (32); alloc_valid=1; stall_out=0; free_count=32;
//   overflow_err=0. Reset mid-operation discards all in-flight state.
//  Allocate: alloc_tag=fl[head] combinational, zero latency. On posedge with
//   alloc_req&alloc_valid: head+=1, count-=1. Next tag appears next cycle.
//  Empty (count=0): alloc_valid=0, alloc_tag holds fl[head] (don't-care),
//   stall_out=alloc_req. No pop occurs.
//  Release: tags are accepted only when valid and tag!=0; p0 (x0) is never freed.
//   Accepted writes go in slot order: rel0 at fl[tail], rel1 at fl[tail+1].
//   When only rel1 is accepted, it is written at fl[tail]. tail += number accepted.
//  Full: a release that would exceed FL_DEPTH is dropped and sets overflow_err.
//   Evaluation uses count after this cycle's pop. overflow_err clears only on reset.
//  Simultaneous alloc+release: there is no bypass, so a tag freed this cycle is not
//   allocatable until next cycle. Empty+release+alloc_req -> stall_out=1 that cycle.
//  count_next = count - pop + accepted_releases; free_count = count (registered).
//  No flush/checkpoint support in this revision; misprediction recovery is out of
//   scope.
// STRUCTURE
//  Shared package cpu_pkg: NUM_PREGS, NUM_AREGS, TAG_W, and the typedef ptag_t
//   (logic [TAG_W-1:0]), also used by rename and the unified issue queue.
//  One sub-module is natural: fl_ptr_inc, a wrapping pointer increment by 0/1/2.
//   Everything else stays flat in this module.
// TESTING
//  Reset, no requests -> alloc_tag=32, alloc_valid=1, free_count=32, stall_out=0.
//  alloc_req high 32 cycles -> tags 32..63 in order.
//   Cycle 33 then gives alloc_valid=0 and stall_out=1 with free_count=0.
//  Drained list; rel0=40, rel1=45 in one cycle -> next cycle free_count=2,
//   then allocations return 40 then 45.
//  Empty list, rel0_tag=50 and alloc_req in the same cycle -> stall_out=1 that cycle.
//   Next cycle alloc_tag=50 and alloc_valid=1.
//  Full list; rel0_tag=33 -> dropped, overflow_err=1, free_count stays 32.
//   rel0_tag=0 on a non-full list -> ignored, count unchanged.
//  Pop 20, release 20, repeat 3 times (pointer wrap).
//   -> FIFO order preserved and free_count returns to 32.
//   Assert rstn=0 mid-run -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Machine-wide sizing shared by rename, the free list and the unified issue queue.
package cpu_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int TAG_W     = $clog2(NUM_PREGS);
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;

  typedef logic [TAG_W-1:0] ptag_t;
endpackage

// File: rtl/fl_ptr_inc.sv
// Circular-buffer pointer advance by 0, 1 or 2 entries, wrapping at DEPTH.
module fl_ptr_inc #(
  parameter int DEPTH = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [PW-1:0] ptr,
  input  logic [1:0]    inc,
  output logic [PW-1:0] nxt
);
  logic [PW:0] sum;

  always_comb begin
    sum = {1'b0, ptr} + {{(PW-1){1'b0}}, inc};
    if (sum >= (PW+1)'(DEPTH)) nxt = PW'(sum - (PW+1)'(DEPTH));
    else                       nxt = sum[PW-1:0];
  end
endmodule

// File: rtl/phys_reg_free_list.sv
// Physical tag free list: one allocation per cycle to rename, up to two
// reclaims per cycle from commit, with a sticky flag for dropped releases.
module phys_reg_free_list
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  output logic             stall_out,
  input  logic             rel0_valid,
  input  logic [TAG_W-1:0] rel0_tag,
  input  logic             rel1_valid,
  input  logic [TAG_W-1:0] rel1_tag,
  output logic [TAG_W-1:0] free_count,
  output logic             overflow_err
);
  localparam int PW = $clog2(FL_DEPTH);
  localparam int CW = $clog2(FL_DEPTH + 1);

  ptag_t [FL_DEPTH-1:0] fl;
  logic [PW-1:0] head, tail, head_nxt, tail_nxt, tail_p1;
  logic [CW-1:0] count, count_pop, space;
  logic          pop, v0, v1, acc0, acc1, drop;
  logic [1:0]    n_acc;

  assign alloc_valid = (count != '0);
  assign alloc_tag   = fl[head];
  assign stall_out   = alloc_req & ~alloc_valid;
  assign free_count  = TAG_W'(count);
  assign pop         = alloc_req & alloc_valid;

  // Room for releases is judged after this cycle's pop; p0 is never reclaimed.
  always_comb begin
    count_pop = count - CW'(pop);
    space     = CW'(FL_DEPTH) - count_pop;
    v0        = rel0_valid & (rel0_tag != '0);
    v1        = rel1_valid & (rel1_tag != '0);
    acc0      = v0 & (space != '0);
    acc1      = v1 & (acc0 ? (space >= CW'(2)) : (space != '0));
    n_acc     = {1'b0, acc0} + {1'b0, acc1};
    drop      = (v0 & ~acc0) | (v1 & ~acc1);
  end

  fl_ptr_inc #(.DEPTH(FL_DEPTH)) u_head_inc (.ptr(head), .inc({1'b0, pop}), .nxt(head_nxt));
  fl_ptr_inc #(.DEPTH(FL_DEPTH)) u_tail_inc (.ptr(tail), .inc(n_acc),       .nxt(tail_nxt));
  fl_ptr_inc #(.DEPTH(FL_DEPTH)) u_tail_p1  (.ptr(tail), .inc(2'd1),        .nxt(tail_p1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= ptag_t'(NUM_AREGS + i);
      head         <= '0;
      tail         <= '0;
      count        <= CW'(FL_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      // A lone slot-1 release packs into the tail slot, not tail+1.
      if (acc0) fl[tail] <= rel0_tag;
      if (acc1) fl[acc0 ? tail_p1 : tail] <= rel1_tag;
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_pop + CW'(n_acc);
      if (drop) overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scenario bench for phys_reg_free_list against a queue-based model of the free list.
module tb_phys_reg_free_list;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             rstn;
  logic             alloc_req;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_valid;
  logic             stall_out;
  logic             rel0_valid;
  logic [TAG_W-1:0] rel0_tag;
  logic             rel1_valid;
  logic [TAG_W-1:0] rel1_tag;
  logic [TAG_W-1:0] free_count;
  logic             overflow_err;

  int checks = 0;
  int fails  = 0;
  int m_q[$];
  bit m_ovf;

  phys_reg_free_list dut (
    .clk(clk), .rstn(rstn), .alloc_req(alloc_req), .alloc_tag(alloc_tag),
    .alloc_valid(alloc_valid), .stall_out(stall_out),
    .rel0_valid(rel0_valid), .rel0_tag(rel0_tag),
    .rel1_valid(rel1_valid), .rel1_tag(rel1_tag),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) m_q.push_back(NUM_AREGS + i);
    m_ovf = 1'b0;
  endtask

  task automatic set_in(input logic a, input logic v0, input int t0, input logic v1, input int t1);
    alloc_req  = a;
    rel0_valid = v0;
    rel0_tag   = t0[TAG_W-1:0];
    rel1_valid = v1;
    rel1_tag   = t1[TAG_W-1:0];
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    if (alloc_req && m_q.size() > 0) void'(m_q.pop_front());
    if (rel0_valid && rel0_tag != 0) begin
      if (m_q.size() < FL_DEPTH) m_q.push_back(int'(rel0_tag)); else m_ovf = 1'b1;
    end
    if (rel1_valid && rel1_tag != 0) begin
      if (m_q.size() < FL_DEPTH) m_q.push_back(int'(rel1_tag)); else m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (alloc_tag !== 6'd32 || alloc_valid !== 1'b1 || free_count !== 6'd32 ||
        stall_out !== 1'b0 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: tag=%0d valid=%b cnt=%0d stall=%b ovf=%b, want 32/1/32/0/0",
               alloc_tag, alloc_valid, free_count, stall_out, overflow_err);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_drain();
    for (int i = 0; i < FL_DEPTH; i++) begin
      set_in(1, 0, 0, 0, 0);
      #1;
      checks++;
      if (alloc_tag !== TAG_W'(NUM_AREGS + i) || alloc_valid !== 1'b1 || stall_out !== 1'b0) begin
        fails++;
        $display("FAIL drain_tag[%0d]: tag=%0d valid=%b stall=%b, want %0d/1/0",
                 i, alloc_tag, alloc_valid, stall_out, NUM_AREGS + i);
      end
      tick();
    end
    set_in(1, 0, 0, 0, 0);
    #1;
    checks++;
    if (alloc_valid !== 1'b0 || stall_out !== 1'b1 || free_count !== 6'd0) begin
      fails++;
      $display("FAIL drain_empty: valid=%b stall=%b cnt=%0d, want 0/1/0",
               alloc_valid, stall_out, free_count);
    end
    tick();
  endtask

  task automatic test_release_pair();
    set_in(0, 1, 40, 1, 45);
    #1;
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (free_count !== 6'd2 || alloc_valid !== 1'b1) begin
      fails++;
      $display("FAIL pair_count: cnt=%0d valid=%b, want 2/1", free_count, alloc_valid);
    end
    set_in(1, 0, 0, 0, 0);
    #1;
    checks++;
    if (alloc_tag !== 6'd40) begin
      fails++;
      $display("FAIL pair_first: tag=%0d, want 40", alloc_tag);
    end
    tick();
    #1;
    checks++;
    if (alloc_tag !== 6'd45 || alloc_valid !== 1'b1) begin
      fails++;
      $display("FAIL pair_second: tag=%0d valid=%b, want 45/1", alloc_tag, alloc_valid);
    end
    tick();
  endtask

  task automatic test_empty_release();
    set_in(1, 1, 50, 0, 0);
    #1;
    checks++;
    if (stall_out !== 1'b1 || alloc_valid !== 1'b0) begin
      fails++;
      $display("FAIL nobypass_stall: stall=%b valid=%b, want 1/0", stall_out, alloc_valid);
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (alloc_tag !== 6'd50 || alloc_valid !== 1'b1 || free_count !== 6'd1) begin
      fails++;
      $display("FAIL nobypass_next: tag=%0d valid=%b cnt=%0d, want 50/1/1",
               alloc_tag, alloc_valid, free_count);
    end
    set_in(1, 0, 0, 0, 0);
    #1;
    tick();
    // slot 1 alone, and slot 1 alongside an ignored p0 release, both pack at the tail
    set_in(0, 0, 0, 1, 55);
    #1;
    tick();
    set_in(0, 1, 0, 1, 57);
    #1;
    tick();
    set_in(1, 0, 0, 0, 0);
    #1;
    checks++;
    if (alloc_tag !== 6'd55 || free_count !== 6'd2) begin
      fails++;
      $display("FAIL rel1_only_first: tag=%0d cnt=%0d, want 55/2", alloc_tag, free_count);
    end
    tick();
    #1;
    checks++;
    if (alloc_tag !== 6'd57 || alloc_valid !== 1'b1) begin
      fails++;
      $display("FAIL rel1_only_second: tag=%0d valid=%b, want 57/1", alloc_tag, alloc_valid);
    end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    // full list: pop frees one slot this cycle, so a single release fits
    set_in(1, 1, 35, 0, 0);
    #1;
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (overflow_err !== 1'b0 || free_count !== 6'd32 || alloc_tag !== 6'd33) begin
      fails++;
      $display("FAIL full_pop_release: ovf=%b cnt=%0d tag=%0d, want 0/32/33",
               overflow_err, free_count, alloc_tag);
    end
    set_in(0, 1, 33, 0, 0);
    #1;
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (overflow_err !== 1'b1 || free_count !== 6'd32) begin
      fails++;
      $display("FAIL full_drop: ovf=%b cnt=%0d, want 1/32", overflow_err, free_count);
    end
    do_reset();
    set_in(1, 0, 0, 0, 0);
    #1;
    tick();
    set_in(0, 1, 0, 0, 0);
    #1;
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (free_count !== 6'd31 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL p0_ignored: cnt=%0d ovf=%b, want 31/0", free_count, overflow_err);
    end
    set_in(0, 1, 32, 1, 34);
    #1;
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (free_count !== 6'd32 || overflow_err !== 1'b1) begin
      fails++;
      $display("FAIL one_slot_two_rel: cnt=%0d ovf=%b, want 32/1", free_count, overflow_err);
    end
  endtask

  task automatic test_wrap();
    int held[$];
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      held.delete();
      for (int i = 0; i < 20; i++) begin
        set_in(1, 0, 0, 0, 0);
        #1;
        checks++;
        if (alloc_tag !== TAG_W'(m_q[0]) || alloc_valid !== 1'b1) begin
          fails++;
          $display("FAIL wrap_pop[%0d/%0d]: tag=%0d valid=%b, want %0d/1",
                   rep, i, alloc_tag, alloc_valid, m_q[0]);
        end
        held.push_back(int'(alloc_tag));
        tick();
      end
      for (int i = 0; i < 10; i++) begin
        set_in(0, 1, held[2*i], 1, held[2*i+1]);
        #1;
        tick();
      end
      set_in(0, 0, 0, 0, 0);
      #1;
      checks++;
      if (free_count !== 6'd32 || overflow_err !== 1'b0) begin
        fails++;
        $display("FAIL wrap_count[%0d]: cnt=%0d ovf=%b, want 32/0", rep, free_count, overflow_err);
      end
    end
    for (int i = 0; i < FL_DEPTH; i++) begin
      set_in(1, 0, 0, 0, 0);
      #1;
      checks++;
      if (alloc_tag !== TAG_W'(m_q[0])) begin
        fails++;
        $display("FAIL wrap_order[%0d]: tag=%0d, want %0d", i, alloc_tag, m_q[0]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic a, v0, v1;
    int t0, t1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      a  = ($urandom_range(0, 9) < 6);
      v0 = ($urandom_range(0, 99) < 35);
      v1 = ($urandom_range(0, 99) < 35);
      t0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, NUM_PREGS - 1));
      t1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, NUM_PREGS - 1));
      set_in(a, v0, t0, v1, t1);
      #1;
      checks++;
      if (alloc_valid !== (m_q.size() > 0) || free_count !== TAG_W'(m_q.size()) ||
          stall_out !== (a && m_q.size() == 0) || overflow_err !== m_ovf ||
          (m_q.size() > 0 && alloc_tag !== TAG_W'(m_q[0]))) begin
        fails++;
        $display("FAIL random[%0d]: tag=%0d valid=%b cnt=%0d stall=%b ovf=%b, want head=%0d cnt=%0d ovf=%b",
                 c, alloc_tag, alloc_valid, free_count, stall_out, overflow_err,
                 (m_q.size() > 0) ? m_q[0] : -1, m_q.size(), m_ovf);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 0);
      #1;
      tick();
    end
    rstn = 1'b0;
    set_in(1, 1, 40, 1, 41);
    model_reset();
    #1;
    checks++;
    if (alloc_tag !== 6'd32 || alloc_valid !== 1'b1 || free_count !== 6'd32 ||
        stall_out !== 1'b0 || overflow_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: tag=%0d valid=%b cnt=%0d stall=%b ovf=%b, want 32/1/32/0/0",
               alloc_tag, alloc_valid, free_count, stall_out, overflow_err);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (alloc_tag !== 6'd32 || free_count !== 6'd32) begin
      fails++;
      $display("FAIL reset_hold: tag=%0d cnt=%0d, want 32/32", alloc_tag, free_count);
    end
    set_in(0, 0, 0, 0, 0);
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    test_reset();
    test_drain();
    test_release_pair();
    test_empty_release();
    test_overflow();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
